// File: rtl/synth_pkg.sv
// Shared types and defaults for the polyphonic voice allocator.
// Voice and control-FSM state encodings live here so sub-modules agree.
package synth_pkg;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_VEL_SHIFT  = 5;

    typedef enum logic [1:0] {
        V_FREE      = 2'd0,
        V_HELD      = 2'd1,
        V_RELEASING = 2'd2
    } voiceState_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_ASSIGN = 2'd2
    } fsmState_t;

endpackage

// File: rtl/voice_select.sv
// Combinational note-on target picker: retrigger, then free,
// then releasing, then steal the oldest held voice.
module voice_select
    import synth_pkg::*;
#(
    parameter  int NUM_VOICES = DEF_NUM_VOICES,
    localparam int IW         = $clog2(NUM_VOICES)
) (
    input  logic [2*NUM_VOICES-1:0] states,
    input  logic [7*NUM_VOICES-1:0] keys,
    input  logic [8*NUM_VOICES-1:0] ages,
    input  logic [6:0]              key,
    output logic [IW-1:0]           target
);
    logic          hitRetrig, hitFree, hitRel;
    logic [IW-1:0] retrigIdx, freeIdx, relIdx, oldIdx;
    logic [7:0]    oldAge;

    always_comb begin
        hitRetrig = 1'b0;
        hitFree   = 1'b0;
        hitRel    = 1'b0;
        retrigIdx = '0;
        freeIdx   = '0;
        relIdx    = '0;
        oldIdx    = '0;
        oldAge    = '0;
        // Walk downwards so the lowest matching index is left standing.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (states[2*i +: 2] == V_HELD && keys[7*i +: 7] == key) begin
                hitRetrig = 1'b1;
                retrigIdx = IW'(i);
            end
            if (states[2*i +: 2] == V_FREE) begin
                hitFree = 1'b1;
                freeIdx = IW'(i);
            end
            if (states[2*i +: 2] == V_RELEASING) begin
                hitRel = 1'b1;
                relIdx = IW'(i);
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (states[2*i +: 2] == V_HELD && ages[8*i +: 8] > oldAge) begin
                oldAge = ages[8*i +: 8];
                oldIdx = IW'(i);
            end
        end
        if (hitRetrig)    target = retrigIdx;
        else if (hitFree) target = freeIdx;
        else if (hitRel)  target = relIdx;
        else              target = oldIdx;
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note-event FSM driving per-voice gates,
// plus an independent one-voice-per-cycle sample strobe sweep.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int VEL_SHIFT  = DEF_VEL_SHIFT
) (
    input  logic                     inClock,
    input  logic                     inReset,
    input  logic                     inNoteValid,
    output logic                     outNoteReady,
    input  logic                     inNoteOn,
    input  logic [6:0]               inNoteKey,
    input  logic [6:0]               inNoteVelocity,
    input  logic                     inSampleTick,
    input  logic [NUM_VOICES-1:0]    inVoiceSilent,
    output logic [NUM_VOICES-1:0]    outIsPlaying,
    output logic [12*NUM_VOICES-1:0] outVelocity,
    output logic [7*NUM_VOICES-1:0]  outKey,
    output logic [NUM_VOICES-1:0]    outSampleReady,
    output logic                     outTickDropped
);
    localparam int IW = $clog2(NUM_VOICES);

    fsmState_t               state, nextState;
    voiceState_t             voiceState [NUM_VOICES];
    logic [7:0]              age [NUM_VOICES];
    logic [2*NUM_VOICES-1:0] packedState;
    logic [8*NUM_VOICES-1:0] packedAge;
    logic [IW-1:0]           selTarget, target;
    logic                    started, accept;
    logic                    evOn;
    logic [6:0]              evKey, evVel;

    // Holds readiness low until the first edge after reset release.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) started <= 1'b0;
        else         started <= 1'b1;
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) state <= S_IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState    = state;
        accept       = 1'b0;
        outNoteReady = 1'b0;
        unique case (state)
            S_IDLE: begin
                outNoteReady = started;
                if (started && inNoteValid) begin
                    accept    = 1'b1;
                    nextState = S_SEARCH;
                end
            end
            S_SEARCH: nextState = S_ASSIGN;
            S_ASSIGN: nextState = S_IDLE;
            default:  nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            evOn   <= 1'b0;
            evKey  <= '0;
            evVel  <= '0;
            target <= '0;
        end else begin
            if (accept) begin
                evOn  <= inNoteOn && (inNoteVelocity != 7'd0);
                evKey <= inNoteKey;
                evVel <= inNoteVelocity;
            end
            if (state == S_SEARCH) target <= selTarget;
        end
    end

    always_comb begin
        packedState = '0;
        packedAge   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            packedState[2*i +: 2] = voiceState[i];
            packedAge[8*i +: 8]   = age[i];
            outIsPlaying[i]       = (voiceState[i] == V_HELD);
        end
    end

    voice_select #(.NUM_VOICES(NUM_VOICES)) uSelect (
        .states (packedState),
        .keys   (outKey),
        .ages   (packedAge),
        .key    (evKey),
        .target (selTarget)
    );

    // Later assignments win, so an ASSIGN overrides a same-cycle silent release.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                voiceState[i] <= V_FREE;
                age[i]        <= '0;
            end
            outKey      <= '0;
            outVelocity <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voiceState[i] == V_RELEASING && inVoiceSilent[i])
                    voiceState[i] <= V_FREE;
                if (state == S_ASSIGN) begin
                    if (evOn) begin
                        if (IW'(i) == target) begin
                            voiceState[i]        <= V_HELD;
                            age[i]               <= '0;
                            outKey[7*i +: 7]     <= evKey;
                            outVelocity[12*i +: 12] <= 12'(evVel) << VEL_SHIFT;
                        end else if (voiceState[i] == V_HELD && age[i] != 8'hFF) begin
                            age[i] <= age[i] + 8'd1;
                        end
                    end else if (voiceState[i] == V_HELD &&
                                 outKey[7*i +: 7] == evKey) begin
                        voiceState[i] <= V_RELEASING;
                    end
                end
            end
        end
    end

    // One-hot shift register: a tick seeds bit 0, then it walks out the top.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            outSampleReady <= '0;
            outTickDropped <= 1'b0;
        end else begin
            outTickDropped <= inSampleTick && (outSampleReady != '0);
            if (outSampleReady != '0)
                outSampleReady <= outSampleReady << 1;
            else if (inSampleTick)
                outSampleReady <= NUM_VOICES'(1);
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator with a behavioural voice model.
// Directed scenarios first, then randomized note/silence traffic.
module tb_voice_allocator;

    localparam int NV   = 4;
    localparam int VS   = 5;
    localparam int FREE = 0;
    localparam int HELD = 1;
    localparam int REL  = 2;

    logic            inClock = 1'b0;
    logic            inReset = 1'b1;
    logic            inNoteValid = 1'b0;
    logic            outNoteReady;
    logic            inNoteOn = 1'b0;
    logic [6:0]      inNoteKey = '0;
    logic [6:0]      inNoteVelocity = '0;
    logic            inSampleTick = 1'b0;
    logic [NV-1:0]   inVoiceSilent = '0;
    logic [NV-1:0]   outIsPlaying;
    logic [12*NV-1:0] outVelocity;
    logic [7*NV-1:0] outKey;
    logic [NV-1:0]   outSampleReady;
    logic            outTickDropped;

    int nTests = 0;
    int nFail  = 0;

    int mSt  [NV];
    int mKey [NV];
    int mVel [NV];
    int mAge [NV];

    voice_allocator #(.NUM_VOICES(NV), .VEL_SHIFT(VS)) dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inNoteValid    (inNoteValid),
        .outNoteReady   (outNoteReady),
        .inNoteOn       (inNoteOn),
        .inNoteKey      (inNoteKey),
        .inNoteVelocity (inNoteVelocity),
        .inSampleTick   (inSampleTick),
        .inVoiceSilent  (inVoiceSilent),
        .outIsPlaying   (outIsPlaying),
        .outVelocity    (outVelocity),
        .outKey         (outKey),
        .outSampleReady (outSampleReady),
        .outTickDropped (outTickDropped)
    );

    always #5 inClock = ~inClock;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void modelReset();
        for (int i = 0; i < NV; i++) begin
            mSt[i] = FREE; mKey[i] = 0; mVel[i] = 0; mAge[i] = 0;
        end
    endfunction

    function automatic void modelNote(input bit on, input int k, input int v);
        int t;
        int best;
        if (!on || v == 0) begin
            for (int i = 0; i < NV; i++)
                if (mSt[i] == HELD && mKey[i] == k) mSt[i] = REL;
            return;
        end
        t = -1;
        for (int i = 0; i < NV; i++) if (t < 0 && mSt[i] == HELD && mKey[i] == k) t = i;
        for (int i = 0; i < NV; i++) if (t < 0 && mSt[i] == FREE) t = i;
        for (int i = 0; i < NV; i++) if (t < 0 && mSt[i] == REL) t = i;
        if (t < 0) begin
            best = -1;
            for (int i = 0; i < NV; i++)
                if (mAge[i] > best) begin best = mAge[i]; t = i; end
        end
        for (int i = 0; i < NV; i++)
            if (i != t && mSt[i] == HELD && mAge[i] < 255) mAge[i]++;
        mSt[t] = HELD; mAge[t] = 0; mKey[t] = k; mVel[t] = v * (1 << VS);
    endfunction

    function automatic void modelSilent(input logic [NV-1:0] m);
        for (int i = 0; i < NV; i++)
            if (m[i] && mSt[i] == REL) mSt[i] = FREE;
    endfunction

    function automatic logic [NV-1:0] expPlay();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = (mSt[i] == HELD);
        return r;
    endfunction

    function automatic logic [7*NV-1:0] expKeys();
        logic [7*NV-1:0] r;
        for (int i = 0; i < NV; i++) r[7*i +: 7] = 7'(mKey[i]);
        return r;
    endfunction

    function automatic logic [12*NV-1:0] expVels();
        logic [12*NV-1:0] r;
        for (int i = 0; i < NV; i++) r[12*i +: 12] = 12'(mVel[i]);
        return r;
    endfunction

    // Drives one event and returns just after the edge that ends ASSIGN.
    task automatic sendNote(input bit on, input int k, input int v);
        int n;
        n = 0;
        while (outNoteReady !== 1'b1 && n < 20) begin
            @(posedge inClock); #1; n++;
        end
        nTests++;
        if (outNoteReady !== 1'b1) begin
            nFail++;
            $display("FAIL ready_wait got %b want 1", outNoteReady);
        end
        inNoteValid = 1'b1; inNoteOn = on;
        inNoteKey = 7'(k); inNoteVelocity = 7'(v);
        @(posedge inClock); #1;
        inNoteValid = 1'b0;
        @(posedge inClock); @(posedge inClock); #1;
        modelNote(on, k, v);
    endtask

    task automatic pulseSilent(input logic [NV-1:0] m);
        inVoiceSilent = m;
        @(posedge inClock); #1;
        inVoiceSilent = '0;
        modelSilent(m);
    endtask

    task automatic test_reset();
        @(negedge inClock); @(negedge inClock);
        nTests += 3;
        if (outNoteReady !== 1'b0) begin
            nFail++; $display("FAIL rst_ready got %b want 0", outNoteReady);
        end
        if ({outIsPlaying, outSampleReady, outTickDropped} !== '0) begin
            nFail++; $display("FAIL rst_flags got %b %b %b want 0", outIsPlaying, outSampleReady, outTickDropped);
        end
        if ({outKey, outVelocity} !== '0) begin
            nFail++; $display("FAIL rst_data got %h %h want 0", outKey, outVelocity);
        end
        inReset = 1'b0;
        modelReset();
        #1;
        nTests++;
        if (outNoteReady !== 1'b0) begin
            nFail++; $display("FAIL rst_ready_pre_edge got %b want 0", outNoteReady);
        end
        @(posedge inClock); #1;
        nTests++;
        if (outNoteReady !== 1'b1) begin
            nFail++; $display("FAIL rst_ready_post_edge got %b want 1", outNoteReady);
        end
    endtask

    task automatic test_first_note();
        inNoteValid = 1'b1; inNoteOn = 1'b1; inNoteKey = 7'd60; inNoteVelocity = 7'd100;
        @(posedge inClock); #1;
        inNoteValid = 1'b0;
        nTests += 2;
        if (outNoteReady !== 1'b0) begin
            nFail++; $display("FAIL first_busy got %b want 0", outNoteReady);
        end
        @(posedge inClock); #1;
        if (outIsPlaying !== 4'b0000) begin
            nFail++; $display("FAIL first_early got %b want 0000", outIsPlaying);
        end
        @(posedge inClock); #1;
        modelNote(1'b1, 60, 100);
        nTests += 3;
        if (outIsPlaying !== 4'b0001) begin
            nFail++; $display("FAIL first_play got %b want 0001", outIsPlaying);
        end
        if (outVelocity[11:0] !== 12'd3200 || outKey[6:0] !== 7'd60) begin
            nFail++; $display("FAIL first_vel got %0d/%0d want 3200/60", outVelocity[11:0], outKey[6:0]);
        end
        if (outNoteReady !== 1'b1) begin
            nFail++; $display("FAIL first_ready got %b want 1", outNoteReady);
        end
    endtask

    task automatic test_steal();
        sendNote(1'b1, 62, 100);
        sendNote(1'b1, 64, 100);
        sendNote(1'b1, 65, 100);
        sendNote(1'b1, 67, 100);
        nTests += 3;
        if (outKey !== {7'd65, 7'd64, 7'd62, 7'd67}) begin
            nFail++; $display("FAIL steal_keys got %h want %h", outKey, {7'd65, 7'd64, 7'd62, 7'd67});
        end
        if (outIsPlaying !== 4'b1111) begin
            nFail++; $display("FAIL steal_play got %b want 1111", outIsPlaying);
        end
        if (outKey !== expKeys() || outVelocity !== expVels()) begin
            nFail++; $display("FAIL steal_model got %h/%h want %h/%h", outKey, outVelocity, expKeys(), expVels());
        end
    endtask

    task automatic test_release();
        sendNote(1'b0, 62, 0);
        nTests++;
        if (outIsPlaying !== 4'b1101) begin
            nFail++; $display("FAIL rel_off got %b want 1101", outIsPlaying);
        end
        // Silence on voice 1 lands in the ASSIGN cycle that targets it.
        inNoteValid = 1'b1; inNoteOn = 1'b1; inNoteKey = 7'd70; inNoteVelocity = 7'd50;
        @(posedge inClock); #1;
        inNoteValid = 1'b0;
        @(posedge inClock); #1;
        inVoiceSilent = 4'b0010;
        @(posedge inClock); #1;
        inVoiceSilent = '0;
        modelNote(1'b1, 70, 50);
        nTests += 2;
        if (outIsPlaying !== 4'b1111) begin
            nFail++; $display("FAIL rel_prec_play got %b want 1111", outIsPlaying);
        end
        if (outKey[13:7] !== 7'd70 || outVelocity[23:12] !== 12'd1600) begin
            nFail++; $display("FAIL rel_prec_data got %0d/%0d want 70/1600", outKey[13:7], outVelocity[23:12]);
        end
        sendNote(1'b0, 70, 0);
        sendNote(1'b0, 64, 0);
        pulseSilent(4'b1101);
        nTests++;
        if (outIsPlaying !== 4'b1001) begin
            nFail++; $display("FAIL rel_silent got %b want 1001", outIsPlaying);
        end
        sendNote(1'b1, 72, 90);
        nTests += 2;
        if (outKey[20:14] !== 7'd72 || outIsPlaying !== 4'b1101) begin
            nFail++; $display("FAIL rel_free_first got %0d/%b want 72/1101", outKey[20:14], outIsPlaying);
        end
        if (outKey !== expKeys() || outVelocity !== expVels()) begin
            nFail++; $display("FAIL rel_model got %h/%h want %h/%h", outKey, outVelocity, expKeys(), expVels());
        end
    endtask

    task automatic test_sweep();
        @(negedge inClock);
        inSampleTick = 1'b1;
        inNoteValid = 1'b1; inNoteOn = 1'b1; inNoteKey = 7'd80; inNoteVelocity = 7'd7;
        @(negedge inClock);
        inSampleTick = 1'b0; inNoteValid = 1'b0;
        nTests++;
        if (outSampleReady !== 4'b0001) begin
            nFail++; $display("FAIL sweep_t1 got %b want 0001", outSampleReady);
        end
        @(negedge inClock);
        nTests++;
        if (outSampleReady !== 4'b0010) begin
            nFail++; $display("FAIL sweep_t2 got %b want 0010", outSampleReady);
        end
        inSampleTick = 1'b1;
        @(negedge inClock);
        inSampleTick = 1'b0;
        modelNote(1'b1, 80, 7);
        nTests += 3;
        if (outSampleReady !== 4'b0100 || outTickDropped !== 1'b1) begin
            nFail++; $display("FAIL sweep_t3 got %b/%b want 0100/1", outSampleReady, outTickDropped);
        end
        if (outIsPlaying !== expPlay() || outKey !== expKeys()) begin
            nFail++; $display("FAIL sweep_note got %b/%h want %b/%h", outIsPlaying, outKey, expPlay(), expKeys());
        end
        if (outVelocity !== expVels()) begin
            nFail++; $display("FAIL sweep_note_vel got %h want %h", outVelocity, expVels());
        end
        @(negedge inClock);
        nTests++;
        if (outSampleReady !== 4'b1000 || outTickDropped !== 1'b0) begin
            nFail++; $display("FAIL sweep_t4 got %b/%b want 1000/0", outSampleReady, outTickDropped);
        end
        @(negedge inClock);
        nTests++;
        if (outSampleReady !== 4'b0000 || outTickDropped !== 1'b0) begin
            nFail++; $display("FAIL sweep_t5 got %b/%b want 0000/0", outSampleReady, outTickDropped);
        end
    endtask

    task automatic test_reset_midsweep();
        @(negedge inClock);
        inSampleTick = 1'b1;
        inNoteValid = 1'b1; inNoteOn = 1'b1; inNoteKey = 7'd90; inNoteVelocity = 7'd20;
        @(negedge inClock);
        inSampleTick = 1'b0; inNoteValid = 1'b0;
        @(posedge inClock); #2;
        inReset = 1'b1;
        #1;
        modelReset();
        nTests += 3;
        if ({outSampleReady, outTickDropped, outNoteReady} !== '0) begin
            nFail++; $display("FAIL mid_rst_flags got %b/%b/%b want 0", outSampleReady, outTickDropped, outNoteReady);
        end
        if (outIsPlaying !== '0) begin
            nFail++; $display("FAIL mid_rst_play got %b want 0", outIsPlaying);
        end
        if ({outKey, outVelocity} !== '0) begin
            nFail++; $display("FAIL mid_rst_data got %h/%h want 0", outKey, outVelocity);
        end
        @(negedge inClock);
        inReset = 1'b0;
        #1;
        nTests++;
        if (outNoteReady !== 1'b0) begin
            nFail++; $display("FAIL mid_rst_ready_pre got %b want 0", outNoteReady);
        end
        @(posedge inClock); #1;
        nTests++;
        if (outNoteReady !== 1'b1) begin
            nFail++; $display("FAIL mid_rst_ready got %b want 1", outNoteReady);
        end
        for (int c = 0; c < 6; c++) begin
            nTests++;
            if (outIsPlaying !== '0 || outSampleReady !== '0 || outTickDropped !== 1'b0) begin
                nFail++;
                $display("FAIL mid_rst_quiet cycle %0d got %b/%b/%b want 0", c, outIsPlaying, outSampleReady, outTickDropped);
            end
            @(posedge inClock); #1;
        end
    endtask

    task automatic test_vel0();
        sendNote(1'b1, 60, 100);
        sendNote(1'b1, 60, 0);
        nTests += 2;
        if (outIsPlaying !== 4'b0000) begin
            nFail++; $display("FAIL vel0_play got %b want 0000", outIsPlaying);
        end
        if (outKey[6:0] !== 7'd60 || outVelocity[11:0] !== 12'd3200) begin
            nFail++; $display("FAIL vel0_keep got %0d/%0d want 60/3200", outKey[6:0], outVelocity[11:0]);
        end
        sendNote(1'b1, 61, 10);
        nTests++;
        if (outIsPlaying !== 4'b0010 || outKey[13:7] !== 7'd61) begin
            nFail++; $display("FAIL vel0_next got %b/%0d want 0010/61", outIsPlaying, outKey[13:7]);
        end
    endtask

    task automatic test_random();
        int r;
        bit on;
        int k;
        int v;
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                pulseSilent(NV'($urandom_range(0, 15)));
            end else begin
                on = ($urandom_range(0, 3) != 0);
                k  = 60 + int'($urandom_range(0, 7));
                v  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 127));
                sendNote(on, k, v);
            end
            nTests += 2;
            if (outIsPlaying !== expPlay()) begin
                nFail++; $display("FAIL rand_play step %0d got %b want %b", n, outIsPlaying, expPlay());
            end
            if (outKey !== expKeys() || outVelocity !== expVels()) begin
                nFail++;
                $display("FAIL rand_data step %0d got %h/%h want %h/%h", n, outKey, outVelocity, expKeys(), expVels());
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_first_note();
        test_steal();
        test_release();
        test_sweep();
        test_reset_midsweep();
        test_vel0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
